imem_loader: RTL

- Boot-loader controller that sequences writes into the 1024-word instruction memory from a byte stream (UART/debug bridge).
- While loading: holds the CPU in reset and disables instruction fetch. Afterwards it releases the CPU so execution restarts at PC 0 with the new program.
- Sits between the byte source, the instruction memory write port, and the CPU reset/ROM-enable lines.

---
 rtl/imem_loader_if.sv | 54 +++++
 rtl/imem_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream, instruction-memory write and CPU-control bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              rom_ce;
    logic              busy;
    logic              done;
    logic              err;

    // master: the loader itself; slave: byte source, memory and CPU side
    modport master (
        input  start,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata,
        output cpu_hold,
        output rom_ce,
        output busy,
        output done,
        output err
    );

    modport slave (
        output start,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata,
        input  cpu_hold,
        input  rom_ce,
        input  busy,
        input  done,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot loader writing a length-prefixed big-endian byte stream into
//            instruction memory while holding the CPU in reset.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input wire            clk,
    input wire            rst,
    imem_loader_if.master bus
);
    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]        c_DEPTH    = 17'(1 << ADDR_W);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LEN_HI = 3'd1;
    localparam logic [2:0] c_LEN_LO = 3'd2;
    localparam logic [2:0] c_RX     = 3'd3;
    localparam logic [2:0] c_WR     = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;
    localparam logic [2:0] c_ERR    = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [15:0]        r_len;
    logic [ADDR_W-1:0]  r_idx;
    logic [23:0]        r_asm;
    logic [1:0]         r_bcnt;
    logic [c_TMO_W-1:0] r_tmo;
    logic [ADDR_W-1:0]  r_waddr;
    logic [31:0]        r_wdata;

    logic        w_ready;
    logic        w_we;
    logic        w_hold;
    logic        w_busy;
    logic        w_done;
    logic        w_err;
    logic        w_accept;
    logic        w_start_ok;
    logic [15:0] w_len_n;
    logic        w_len_bad;
    logic        w_last;
    logic        w_tmo_hit;

    assign w_accept   = bus.byte_valid && w_ready;
    assign w_start_ok = bus.start && ((r_state == c_IDLE) || (r_state == c_ERR));
    assign w_len_n    = {r_len[15:8], bus.byte_data};
    assign w_len_bad  = (w_len_n == 16'd0) || ({1'b0, w_len_n} > c_DEPTH);
    assign w_last     = (17'(r_idx) + 17'd1) == {1'b0, r_len};
    // Fires on the idle cycle that would bring the counter to TIMEOUT_CYC
    assign w_tmo_hit  = w_ready && !w_accept && (r_tmo == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) w_next = c_LEN_HI;
            end
            c_LEN_HI: begin
                if (w_tmo_hit)     w_next = c_ERR;
                else if (w_accept) w_next = c_LEN_LO;
            end
            c_LEN_LO: begin
                if (w_tmo_hit)     w_next = c_ERR;
                else if (w_accept) w_next = w_len_bad ? c_ERR : c_RX;
            end
            c_RX: begin
                if (w_tmo_hit)                          w_next = c_ERR;
                else if (w_accept && (r_bcnt == 2'd3))  w_next = c_WR;
            end
            c_WR: begin
                w_next = w_last ? c_DONE : c_RX;
            end
            c_DONE: begin
                w_next = c_IDLE;
            end
            c_ERR: begin
                if (bus.start) w_next = c_LEN_HI;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_hold  = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            c_LEN_HI, c_LEN_LO, c_RX: begin
                w_ready = 1'b1;
                w_hold  = 1'b1;
                w_busy  = 1'b1;
            end
            c_WR: begin
                w_we   = 1'b1;
                w_hold = 1'b1;
                w_busy = 1'b1;
            end
            c_DONE: begin
                w_done = 1'b1;
            end
            c_ERR: begin
                // Memory is only partially written, so the CPU stays parked
                w_err  = 1'b1;
                w_hold = 1'b1;
            end
            default: begin
                w_hold = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len   <= 16'd0;
            r_idx   <= '0;
            r_asm   <= 24'd0;
            r_bcnt  <= 2'd0;
            r_tmo   <= '0;
            r_waddr <= '0;
            r_wdata <= 32'd0;
        end else begin
            if (w_start_ok) begin
                r_idx <= '0;
                r_tmo <= '0;
            end else if (w_accept) begin
                r_tmo <= '0;
            end else if (w_ready) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end

            if (w_accept) begin
                case (r_state)
                    c_LEN_HI: r_len[15:8] <= bus.byte_data;
                    c_LEN_LO: begin
                        r_len[7:0] <= bus.byte_data;
                        r_bcnt     <= 2'd0;
                    end
                    c_RX: begin
                        r_asm  <= {r_asm[15:0], bus.byte_data};
                        r_bcnt <= r_bcnt + 2'd1;
                        // Latch the write port here so it is stable for the WR cycle
                        if (r_bcnt == 2'd3) begin
                            r_waddr <= r_idx;
                            r_wdata <= {r_asm, bus.byte_data};
                        end
                    end
                    default: r_bcnt <= r_bcnt;
                endcase
            end

            if ((r_state == c_WR) && !w_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.mem_we     = w_we;
    assign bus.mem_waddr  = r_waddr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.cpu_hold   = w_hold;
    assign bus.rom_ce     = ~w_hold;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = w_err;

endmodule
`default_nettype wire
